alu_issue: RTL

Command front-end and result buffer for the 4-bit ALU datapath. Accepts one operation per valid/ready transfer, registers the operands and drives the ALU's select/in_x/in_y/in_c inputs for one execute cycle, then samples out_s/out_c/zero/overflow into a 2-entry result FIFO. A 4-bit accumulator holds the last result and can replace operand A, so operations can be chained without software readback.

---
 rtl/alu_issue.sv | 121 ++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - command front-end, accumulator and 2-entry result FIFO for the 4-bit ALU
module alu_issue (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic       cmd_acc,
    output logic [2:0] select,
    output logic [3:0] in_x,
    output logic [3:0] in_y,
    output logic       in_c,
    input  logic [3:0] out_s,
    input  logic       out_c,
    input  logic       overflow,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_s,
    output logic       res_c,
    output logic       res_zero,
    output logic       res_ovf,
    output logic [2:0] res_op,
    output logic [3:0] acc,
    output logic [7:0] done_cnt
);
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_CMP = 3'b110;
    localparam logic [2:0] OP_CLR = 3'b111;

    typedef enum logic {IDLE, EXEC} state_t;

    typedef struct packed {
        logic [3:0] s;
        logic       c;
        logic       zero;
        logic       ovf;
        logic [2:0] op;
    } entry_t;

    state_t     state;
    entry_t     head;
    entry_t     tail;
    entry_t     push_entry;
    logic [1:0] count;
    logic       push;
    logic       pop;

    assign cmd_ready = (state == IDLE) && (count != 2'd2);
    assign res_valid = (count != 2'd0);
    assign push      = (state == EXEC);
    assign pop       = res_valid && res_ready;
    assign {res_s, res_c, res_zero, res_ovf, res_op} = head;

    // CLR ignores whatever the ALU produces for select 111
    always_comb begin
        push_entry = '0;
        if (select == OP_CLR) begin
            push_entry.zero = 1'b1;
            push_entry.op   = OP_CLR;
        end else begin
            push_entry.s    = out_s;
            push_entry.c    = out_c;
            push_entry.zero = (out_s == 4'd0);
            push_entry.ovf  = overflow;
            push_entry.op   = select;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            select   <= '0;
            in_x     <= '0;
            in_y     <= '0;
            in_c     <= 1'b0;
            acc      <= '0;
            done_cnt <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        select <= cmd_op;
                        in_x   <= cmd_acc ? acc : cmd_a;
                        in_y   <= cmd_b;
                        in_c   <= (cmd_op == OP_SUB) || (cmd_op == OP_CMP);
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    acc      <= push_entry.s;
                    done_cnt <= done_cnt + 8'd1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // head is slot 0; tail is kept zero whenever fewer than two entries are held
            if (push && pop) begin
                if (count == 2'd2) begin
                    head <= tail;
                    tail <= push_entry;
                end else begin
                    head <= push_entry;
                end
            end else if (push) begin
                if (count == 2'd0) head <= push_entry;
                else               tail <= push_entry;
                count <= count + 2'd1;
            end else if (pop) begin
                head  <= tail;
                tail  <= '0;
                count <= count - 2'd1;
            end
        end
    end
endmodule
